// File: rtl/round_counter_pkg.sv
// Shared types and the free-mode step function for the round counter.
package round_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Width-agnostic free-mode step; returns {next, wrap_event}.
  function automatic logic [32:0] free_next(
    input logic [31:0] cur,
    input logic        dir,
    input logic [31:0] max_val,
    input logic        wrap
  );
    logic [31:0] nxt;
    logic        ev;
    nxt = cur;
    ev  = 1'b0;
    if (dir == DIR_UP) begin
      if (cur < max_val) begin
        nxt = cur + 32'd1;
      end else if (wrap) begin
        nxt = '0;
        ev  = 1'b1;
      end
    end else begin
      if (cur != '0) begin
        nxt = cur - 32'd1;
      end else if (wrap) begin
        nxt = max_val;
        ev  = 1'b1;
      end
    end
    return {nxt, ev};
  endfunction

endpackage

// File: rtl/round_counter.sv
// Round/key-schedule index counter: free mode (load/count/wrap or saturate)
// and an autonomous run mode that steps 0..MAX_VAL and pulses done.
module round_counter
  import round_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  input  logic             dir,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             wrapped,
  output state_e           state_dbg
);

  if (MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max
    $error("round_counter: MAX_VAL out of range 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrapped_q, wrapped_d;

  logic [32:0]      free_full;
  logic [WIDTH-1:0] free_out;
  logic             free_wrap;
  logic [WIDTH-1:0] load_clip;

  always_comb begin
    free_full = free_next(32'(out_q), dir, 32'(MAX_VAL), WRAP != 0);
    free_out  = WIDTH'(free_full >> 1);
    free_wrap = free_full[0];
    load_clip = (load_val > MAX_V) ? MAX_V : load_val;
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrapped_d = wrapped_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          out_d     = '0;
          wrapped_d = 1'b0;
        end else if (load) begin
          out_d = load_clip;
        end else if (start) begin
          out_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else if (count) begin
          out_d = free_out;
          if (free_wrap) wrapped_d = 1'b1;
        end
      end
      RUN: begin
        // clr aborts without a done pulse; a run never touches wrapped otherwise.
        if (clr) begin
          out_d     = '0;
          busy_d    = 1'b0;
          wrapped_d = 1'b0;
          state_d   = IDLE;
        end else if (out_q < MAX_V) begin
          out_d = out_q + 1'b1;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        out_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_comb begin
    if (state_q == RUN) begin
      tc = (out_q == MAX_V);
    end else if (dir == DIR_UP) begin
      tc = (out_q == MAX_V);
    end else begin
      tc = (out_q == '0);
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_round_counter.sv
// Bench for round_counter: three configurations driven in lockstep and
// compared against an arithmetic reference model.
module tb_round_counter;
  import round_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rstn, clr, load, count, dir, start;
  logic [3:0] load_val;

  logic [3:0] out_a, out_b;
  logic [1:0] out_c;
  logic       busy_v [3];
  logic       tc_v   [3];
  logic       done_v [3];
  logic       wr_v   [3];
  state_e     sd     [3];

  int n_cmp = 0;
  int n_err = 0;

  int m_out  [3];
  int m_busy [3];
  int m_done [3];
  int m_wr   [3];
  int m_max  [3] = '{9, 9, 3};
  int m_wrap [3] = '{1, 0, 1};
  int m_mask [3] = '{15, 15, 3};

  always #5 clk = ~clk;

  round_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(1)) u_a (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .count(count), .dir(dir), .start(start), .out(out_a), .busy(busy_v[0]),
    .tc(tc_v[0]), .done(done_v[0]), .wrapped(wr_v[0]), .state_dbg(sd[0]));

  round_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(0)) u_b (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .count(count), .dir(dir), .start(start), .out(out_b), .busy(busy_v[1]),
    .tc(tc_v[1]), .done(done_v[1]), .wrapped(wr_v[1]), .state_dbg(sd[1]));

  round_counter #(.WIDTH(2), .MAX_VAL(3), .WRAP(1)) u_c (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val[1:0]),
    .count(count), .dir(dir), .start(start), .out(out_c), .busy(busy_v[2]),
    .tc(tc_v[2]), .done(done_v[2]), .wrapped(wr_v[2]), .state_dbg(sd[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dut_out(input int i);
    case (i)
      0:       return int'(out_a);
      1:       return int'(out_b);
      default: return int'(out_c);
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_out[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_wr[i] = 0;
    end
  endfunction

  function automatic int model_tc(input int i);
    if (m_busy[i] != 0 || dir == 1'b0) return int'(m_out[i] == m_max[i]);
    return int'(m_out[i] == 0);
  endfunction

  // One clock edge of behaviour, straight from the action table.
  function automatic void model_step();
    int lv;
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 0;
      if (m_busy[i] != 0) begin
        if (clr) begin
          m_out[i] = 0; m_busy[i] = 0; m_wr[i] = 0;
        end else if (m_out[i] < m_max[i]) begin
          m_out[i] = m_out[i] + 1;
        end else begin
          m_busy[i] = 0; m_done[i] = 1;
        end
      end else if (clr) begin
        m_out[i] = 0; m_wr[i] = 0;
      end else if (load) begin
        lv = int'(load_val) & m_mask[i];
        m_out[i] = (lv > m_max[i]) ? m_max[i] : lv;
      end else if (start) begin
        m_out[i] = 0; m_busy[i] = 1;
      end else if (count) begin
        if (!dir) begin
          if (m_out[i] < m_max[i]) m_out[i] = m_out[i] + 1;
          else if (m_wrap[i] != 0) begin m_out[i] = 0; m_wr[i] = 1; end
        end else begin
          if (m_out[i] > 0) m_out[i] = m_out[i] - 1;
          else if (m_wrap[i] != 0) begin m_out[i] = m_max[i]; m_wr[i] = 1; end
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s[%0d].out", tag, i), dut_out(i), m_out[i]);
      check($sformatf("%s[%0d].busy", tag, i), int'(busy_v[i]), m_busy[i]);
      check($sformatf("%s[%0d].done", tag, i), int'(done_v[i]), m_done[i]);
      check($sformatf("%s[%0d].wrapped", tag, i), int'(wr_v[i]), m_wr[i]);
      check($sformatf("%s[%0d].state_run", tag, i), int'(sd[i] == RUN), m_busy[i]);
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input string tag, input logic c, input logic l, input logic [3:0] lv,
                      input logic cn, input logic d, input logic s);
    clr = c; load = l; load_val = lv; count = cn; dir = d; start = s;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("%s[%0d].tc", tag, i), int'(tc_v[i]), model_tc(i));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 0, 0, 4'd0, 0, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    rstn = 1'b0;
    #1;
    model_reset();
    check(tag, int'(out_a), 0);
    check(tag, int'(busy_v[0]), 0);
    check_all(tag);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; clr = 0; load = 0; load_val = 0; count = 0; dir = 0; start = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rstn = 1'b1;
    idle("post_reset", 1);

    // Run mode and back-to-back start in the done cycle.
    step("run_start", 0, 0, 4'd0, 0, 0, 1);
    check("run_first_out", int'(out_a), 0);
    idle("run", 9);
    check("run_last_out", int'(out_a), 9);
    check("run_last_busy", int'(busy_v[0]), 1);
    idle("run_end", 1);
    check("run_done", int'(done_v[0]), 1);
    check("run_done_out", int'(out_a), 9);
    step("b2b_start", 0, 0, 4'd0, 0, 0, 1);
    check("b2b_busy", int'(busy_v[0]), 1);
    check("b2b_out", int'(out_a), 0);
    check("b2b_done_low", int'(done_v[0]), 0);
    idle("b2b", 11);

    // Asynchronous reset in the middle of a run.
    step("rst_run", 0, 0, 4'd0, 0, 0, 1);
    idle("rst_run", 3);
    async_reset("rst_mid");
    idle("rst_after", 2);
    check("rst_after_out", int'(out_a), 0);

    // Wrap vs saturate at both ends, then clr.
    step("wrap_load", 0, 1, 4'd8, 0, 0, 0);
    step("wrap_up", 0, 0, 4'd0, 1, 0, 0);
    check("wrap_up_a", int'(out_a), 9);
    step("wrap_up", 0, 0, 4'd0, 1, 0, 0);
    check("wrap_a_out", int'(out_a), 0);
    check("wrap_a_flag", int'(wr_v[0]), 1);
    check("sat_b_out", int'(out_b), 9);
    check("sat_b_flag", int'(wr_v[1]), 0);
    step("wrap_down", 0, 0, 4'd0, 1, 1, 0);
    check("wrap_down_a", int'(out_a), 9);
    step("wrap_clr", 1, 0, 4'd0, 0, 0, 0);
    check("wrap_clr_flag", int'(wr_v[0]), 0);
    step("sat_load", 0, 1, 4'd9, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("sat_up", 0, 0, 4'd0, 1, 0, 0);
    step("sat_load0", 0, 1, 4'd0, 0, 1, 0);
    step("sat_down", 0, 0, 4'd0, 1, 1, 0);
    check("sat_down_b", int'(out_b), 0);

    // Priority, clipping, ignored load in RUN, clr abort.
    step("prio_all", 1, 1, 4'd7, 1, 0, 1);
    check("prio_no_run", int'(busy_v[0]), 0);
    step("clip", 0, 1, 4'd15, 0, 0, 0);
    check("clip_a", int'(out_a), 9);
    step("prio_start", 0, 0, 4'd0, 0, 0, 1);
    step("run_load", 0, 1, 4'd5, 1, 1, 0);
    idle("run_to4", 3);
    check("run_at4", int'(out_a), 4);
    step("run_abort", 1, 0, 4'd0, 0, 0, 0);
    check("abort_busy", int'(busy_v[0]), 0);
    idle("abort_after", 2);

    // Full-range modulo counting on the 2-bit instance.
    step("mod_clr", 1, 0, 4'd0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step("mod_up", 0, 0, 4'd0, 1, 0, 0);
    check("mod_c_out", int'(out_c), 1);
    check("mod_c_flag", int'(wr_v[2]), 1);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rnd_rst");
        idle("rnd_rst_idle", 1);
      end else begin
        step("rnd", $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
             4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
